// File: rtl/par_ser_pkg.sv
// Shared types and constants for the par_ser_out serial egress stage.
// Optional feature macro used by this slice: PAR_SER_PARITY_EN.
package par_ser_pkg;

  localparam int PAR_DATA_W = 512;
  localparam int PAR_CNT_W  = 10;

  // Largest count that can be serialised from one parallel word.
  localparam logic [PAR_CNT_W-1:0] PAR_MAX_CNT = PAR_CNT_W'(PAR_DATA_W);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } par_ser_state_t;

  // Requested widths beyond the parallel word length serialise the whole word.
  function automatic logic [PAR_CNT_W-1:0] par_ser_clamp(input logic [PAR_CNT_W-1:0] width);
    return (width > PAR_MAX_CNT) ? PAR_MAX_CNT : width;
  endfunction

endpackage

// File: rtl/par_ser_counter.sv
// Loadable down-counter tracking the bits remaining in the current frame.
// `last` flags one bit remaining; `zero` flags an empty counter.
module par_ser_counter
  import par_ser_pkg::*;
#(
  parameter int CNT_W = PAR_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(1));
  assign zero  = (count_q == '0);

endmodule

// File: rtl/par_ser_out.sv
// Parallel-to-serial egress stage: captures a parallel word and a bit count,
// then shifts the low bits out LSB first under a valid/ready handshake.
// Optional feature macro: PAR_SER_PARITY_EN appends an even-parity bit.
//
// Handshake: a serial bit transfers on a rising edge where ser_valid and
// ser_ready are both high; while ser_ready is low, ser_out/ser_valid/ser_last
// hold. A load transfers on a rising edge where load_ready and load_valid are
// both high. All outputs come straight from flops.
module par_ser_out
  import par_ser_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PAR_CNT_W-1:0]  WIDTH,
  input  logic [PAR_DATA_W-1:0] par_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_last,
  output logic                  busy,
  output par_ser_state_t        state_dbg
);

  localparam int DATA_W = PAR_DATA_W;
  localparam int CNT_W  = PAR_CNT_W;

  par_ser_state_t    state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_last_q, ser_last_d;
  logic              busy_q, busy_d;
  logic              load_ready_q, load_ready_d;
`ifdef PAR_SER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [CNT_W-1:0]  eff_cnt;
  logic [CNT_W-1:0]  frame_len;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_last;
  logic              cnt_zero;

  // Effective frame length from the requested width, plus the parity slot.
  always_comb begin
    eff_cnt = par_ser_clamp(WIDTH);
`ifdef PAR_SER_PARITY_EN
    frame_len = (eff_cnt == '0) ? '0 : (eff_cnt + CNT_W'(1));
`else
    frame_len = eff_cnt;
`endif
  end

  assign cnt_load = (state_q == IDLE) && load_valid && (frame_len != '0);
  assign cnt_dec  = (state_q == SHIFT) && ser_ready;

  par_ser_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (frame_len),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    ser_last_d   = ser_last_q;
    busy_d       = busy_q;
    load_ready_d = load_ready_q;
`ifdef PAR_SER_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          // A zero-length load is accepted and dropped without leaving IDLE.
          sreg_d = par_in;
          if (frame_len != '0) begin
            state_d      = SHIFT;
            ser_out_d    = par_in[0];
            ser_valid_d  = 1'b1;
            ser_last_d   = (frame_len == CNT_W'(1));
            busy_d       = 1'b1;
            load_ready_d = 1'b0;
`ifdef PAR_SER_PARITY_EN
            parity_d     = 1'b0;
`endif
          end
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (cnt_last || cnt_zero) begin
            // Final bit accepted: drop valid and reopen for the next load.
            state_d      = IDLE;
            ser_out_d    = 1'b0;
            ser_valid_d  = 1'b0;
            ser_last_d   = 1'b0;
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
          end else begin
            sreg_d     = sreg_q >> 1;
            ser_last_d = (cnt_val == CNT_W'(2));
`ifdef PAR_SER_PARITY_EN
            parity_d   = parity_q ^ sreg_q[0];
            // With two slots left the next one is the parity bit.
            if (cnt_val == CNT_W'(2)) begin
              ser_out_d = parity_q ^ sreg_q[0];
            end else begin
              ser_out_d = sreg_q[1];
            end
`else
            ser_out_d  = sreg_q[1];
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, shift register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef PAR_SER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      ser_last_q   <= ser_last_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
`ifdef PAR_SER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign load_ready = load_ready_q;
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign ser_last   = ser_last_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_par_ser_out.sv
// Self-checking bench for par_ser_out: randomized frames against a
// bit-queue reference model built from the width/data/parity rules.
module tb_par_ser_out;
  import par_ser_pkg::*;

  logic                  clock;
  logic                  reset;
  logic [PAR_CNT_W-1:0]  WIDTH;
  logic [PAR_DATA_W-1:0] par_in;
  logic                  load_valid;
  logic                  load_ready;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  ser_ready;
  logic                  ser_last;
  logic                  busy;
  par_ser_state_t        state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [0:0] exp_q[$];

  par_ser_out dut (
    .clock      (clock),
    .reset      (reset),
    .WIDTH      (WIDTH),
    .par_in     (par_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_last   (ser_last),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: expected bit stream for one load.
  task automatic build_expected(input logic [PAR_CNT_W-1:0] w, input logic [PAR_DATA_W-1:0] d);
    int  n;
    logic par;
    exp_q.delete();
    n   = (int'(w) > PAR_DATA_W) ? PAR_DATA_W : int'(w);
    par = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      par = par ^ d[i];
    end
`ifdef PAR_SER_PARITY_EN
    if (n > 0) exp_q.push_back(par);
`endif
  endtask

  function automatic logic [PAR_DATA_W-1:0] rand_word();
    logic [PAR_DATA_W-1:0] d;
    for (int i = 0; i < PAR_DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Driver + scoreboard for one frame. pat: 0 ready high, 1 ready 1,0,0..., 2 random.
  task automatic run_frame(input logic [PAR_CNT_W-1:0] w, input logic [PAR_DATA_W-1:0] d,
                           input int pat, input bit noise);
    int   len;
    int   cycles;
    logic rdy;
    logic prev_stall;
    logic prev_out;
    logic prev_last;
    build_expected(w, d);
    len = exp_q.size();
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_load_ready: got %b expected 1", load_ready);
    end
    WIDTH      = w;
    par_in     = d;
    load_valid = 1'b1;
    ser_ready  = 1'b0;
    @(negedge clock);
    load_valid = 1'b0;
    if (len == 0) begin
      repeat (3) begin
        tests_run++;
        if (ser_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL zero_width: valid=%b ready=%b busy=%b expected 0/1/0",
                   ser_valid, load_ready, busy);
        end
        @(negedge clock);
      end
      return;
    end
    cycles     = 0;
    prev_stall = 1'b0;
    prev_out   = 1'b0;
    prev_last  = 1'b0;
    while (exp_q.size() > 0 && cycles < 4000) begin
      tests_run++;
      if (ser_valid !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL shift_flags: valid=%b busy=%b load_ready=%b expected 1/1/0 (bits left %0d)",
                 ser_valid, busy, load_ready, exp_q.size());
      end
      tests_run++;
      if (ser_out !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL ser_out: got %b expected %b (bits left %0d)", ser_out, exp_q[0], exp_q.size());
      end
      tests_run++;
      if (ser_last !== (exp_q.size() == 1)) begin
        tests_failed++;
        $display("FAIL ser_last: got %b expected %b (bits left %0d)", ser_last,
                 (exp_q.size() == 1), exp_q.size());
      end
      if (prev_stall) begin
        tests_run++;
        if (ser_out !== prev_out || ser_last !== prev_last) begin
          tests_failed++;
          $display("FAIL stall_hold: out=%b last=%b expected %b/%b", ser_out, ser_last,
                   prev_out, prev_last);
        end
      end
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = ((cycles % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ser_ready = rdy;
      if (noise) begin
        load_valid = 1'($urandom_range(0, 1));
        WIDTH      = PAR_CNT_W'($urandom_range(1, 1023));
        par_in     = ~d;
      end
      prev_stall = !rdy;
      prev_out   = ser_out;
      prev_last  = ser_last;
      @(negedge clock);
      if (rdy) void'(exp_q.pop_front());
      cycles++;
    end
    load_valid = 1'b0;
    ser_ready  = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL frame_timeout: got %0d bits left expected 0", exp_q.size());
    end
    if (pat == 0) begin
      tests_run++;
      if (cycles != len) begin
        tests_failed++;
        $display("FAIL frame_cycles: got %0d expected %0d", cycles, len);
      end
    end
    tests_run++;
    if (load_ready !== 1'b1 || ser_valid !== 1'b0 || busy !== 1'b0 ||
        ser_last !== 1'b0 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL post_frame: ready=%b valid=%b busy=%b last=%b state=%0d expected 1/0/0/0/0",
               load_ready, ser_valid, busy, ser_last, state_dbg);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    WIDTH      = '0;
    par_in     = '0;
    load_valid = 1'b0;
    ser_ready  = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (load_ready !== 1'b1 || ser_valid !== 1'b0 || busy !== 1'b0 ||
          ser_out !== 1'b0 || ser_last !== 1'b0 || state_dbg !== IDLE) begin
        tests_failed++;
        $display("FAIL reset_vals: ready=%b valid=%b busy=%b out=%b last=%b state=%0d expected 1/0/0/0/0/0",
                 load_ready, ser_valid, busy, ser_out, ser_last, state_dbg);
      end
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (load_ready !== 1'b1 || ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset: ready=%b valid=%b expected 1/0", load_ready, ser_valid);
    end
  endtask

  task automatic test_basic();
    logic [PAR_DATA_W-1:0] d;
    d = '0;
    d[3:0] = 4'hB;
    run_frame(10'd4, d, 0, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_stall();
    logic [PAR_DATA_W-1:0] d;
    d = '0;
    d[3:0] = 4'hB;
    run_frame(10'd4, d, 1, 1'b0);
    @(negedge clock);
    run_frame(10'd37, rand_word(), 2, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_boundaries();
    run_frame(10'd0, rand_word(), 0, 1'b0);
    run_frame(10'd1023, {PAR_DATA_W{1'b1}}, 0, 1'b0);
    @(negedge clock);
    run_frame(10'd1, rand_word(), 0, 1'b0);
    @(negedge clock);
    run_frame(10'd512, rand_word(), 2, 1'b0);
    @(negedge clock);
    run_frame(10'd513, rand_word(), 0, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [PAR_CNT_W-1:0] w;
    for (int i = 0; i < 12; i++) begin
      w = ($urandom_range(0, 3) == 0) ? PAR_CNT_W'($urandom_range(0, 1023))
                                      : PAR_CNT_W'($urandom_range(0, 40));
      run_frame(w, rand_word(), 2, 1'b1);
      @(negedge clock);
    end
  endtask

  task automatic test_reset_abort();
    logic [PAR_DATA_W-1:0] d;
    d = rand_word();
    WIDTH      = 10'd8;
    par_in     = d;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    tests_run++;
    if (ser_out !== d[0] || ser_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_bit0: out=%b valid=%b expected %b/1", ser_out, ser_valid, d[0]);
    end
    @(negedge clock);
    tests_run++;
    if (ser_out !== d[1] || ser_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_bit1: out=%b valid=%b expected %b/1", ser_out, ser_valid, d[1]);
    end
    @(negedge clock);
    reset     = 1'b1;
    ser_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if (ser_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL abort_idle: valid=%b ready=%b busy=%b state=%0d expected 0/1/0/0",
               ser_valid, load_ready, busy, state_dbg);
    end
    @(negedge clock);
    tests_run++;
    if (ser_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_quiet: valid=%b expected 0", ser_valid);
    end
    run_frame(10'd3, rand_word(), 0, 1'b0);
    @(negedge clock);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_boundaries();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
